opsum_writeback: RTL and testbench
==================================

OPSUM_WRITEBACK -- requirements
Module: opsum_writeback

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous reset, active-high).
REQ-002 start_i  input  1: single-cycle pulse that launches one drain job.
REQ-003 ch_num_i  input  6: number of active opsum channels, 0..32; the block SHALL sample it on start_i.
REQ-004 words_per_ch_i  input  16: 32-bit words to drain per channel; the block SHALL sample it on start_i.
REQ-005 glb_base_addr_i  input  32 and ch_stride_i  input  32: byte base address and per-channel byte stride; the block SHALL sample both on start_i.
REQ-006 opsum_fifo_empty  input  32: per-channel empty flags from the opsum FIFO bank.
REQ-007 opsum_pop_data  input  32x32: per-channel pop data, {psum_hi[15:0], psum_lo[15:0]}.
REQ-008 opsum_pop_en  output  32: one-hot pop strobe; opsum_pop_mod  output  32: pop mode, with 1 meaning a 32-bit pop of two psums.
REQ-009 glb_we_o  output  1, glb_addr_o  output  32, glb_wdata_o  output  32: GLB write request; glb_ready_i  input  1: GLB accepts the write.
REQ-010 busy_o  output  1 and done_o  output  1: job status.

Function
REQ-011 The FSM SHALL have the states IDLE, SCAN, POP, CAPT, WRITE and DONE.
REQ-012 IDLE -> SCAN on start_i; if ch_num_i==0 or words_per_ch_i==0, IDLE -> DONE directly.
REQ-013 Traversal order SHALL be word-major: for each word w in 0..W-1, visit channels c in 0..C-1 in order.
REQ-014 SCAN: if opsum_fifo_empty[c]==0, go to POP; otherwise stay in SCAN on the same channel (no skip, no timeout).
REQ-015 POP: assert opsum_pop_en[c] for exactly one cycle, with opsum_pop_mod[c]=1 in the same cycle; go to CAPT.
REQ-016 CAPT: register opsum_pop_data[c], which SHALL be valid in the cycle after the pop strobe; go to WRITE.
REQ-017 WRITE: hold glb_we_o=1 with stable addr/data until glb_ready_i==1.
REQ-018 On acceptance, advance c; on wrap of c, advance w; after the last (C-1, W-1) transfer, go to DONE, otherwise go to SCAN.
REQ-019 glb_addr_o SHALL equal base + c*stride + w*4, computed modulo 2^32 with no overflow flag.
REQ-020 DONE: pulse done_o=1 for exactly one cycle, then return to IDLE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 A start_i that arrives while busy_o==1 SHALL be ignored.
REQ-023 Outside POP, opsum_pop_en and opsum_pop_mod SHALL be all-zero, and at most one bit of opsum_pop_en SHALL ever be set.
REQ-024 Best-case throughput SHALL be one word per 4 cycles (SCAN, POP, CAPT, WRITE) when the FIFO is non-empty and glb_ready_i is held high.

Reset
REQ-025 While rst is high at a clock edge, the FSM SHALL go to IDLE, and c, w and all registered configuration SHALL clear to 0.
REQ-026 Reset values SHALL be: opsum_pop_en=0, opsum_pop_mod=0, glb_we_o=0, glb_addr_o=0, glb_wdata_o=0, busy_o=0, done_o=0.
REQ-027 A reset asserted mid-job SHALL abort the job without a done_o pulse; an in-flight write SHALL be dropped.

Configuration
REQ-028 Macro OPSUM_WB_RELU_EN: when defined, each signed 16-bit half of the captured word SHALL be clamped to 0 if negative before the write.
REQ-029 Without OPSUM_WB_RELU_EN, the captured word SHALL be written unmodified; the interface and timing SHALL be identical in both builds.

Structure
REQ-030 The shared package conv_pkg SHALL hold NUM_CH=32, PSUM_W=16, GLB_AW=32 and the state enum typedef opsum_wb_state_t.
REQ-031 Address generation SHALL live in one sub-module, opsum_wb_addr_gen, which holds the channel-base and word-offset accumulators (no multipliers).

Verification
REQ-032 Test 1: C=2, W=2, base=0x1000, stride=0x100, FIFOs pre-filled, ready=1 -> writes go to 0x1000, 0x1100, 0x1004, 0x1104 in that order, and done_o pulses once.
REQ-033 Test 2: channel 1 stays empty for 10 cycles -> the block holds SCAN on c=1, no pop is issued, and it resumes after the FIFO is filled.
REQ-034 Test 3: glb_ready_i is held low for 5 cycles during WRITE -> glb_we_o, glb_addr_o and glb_wdata_o stay stable, and exactly one pop occurs per word.
REQ-035 Test 4: data 0xFFF0_0012 -> with OPSUM_WB_RELU_EN the write is 0x0000_0012; without it the write is 0xFFF0_0012.
REQ-036 Test 5: rst is asserted during the second WRITE -> all outputs are 0 on the next cycle with no done_o; a new start_i then runs cleanly from c=0, w=0.
REQ-037 Test 6: start_i with ch_num_i=0 -> done_o pulses 2 cycles after start_i with no pops and no writes; a second start_i while busy is ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM state type and psum clamp helper
package conv_pkg;

  localparam int NUM_CH = 32;
  localparam int PSUM_W = 16;
  localparam int GLB_AW = 32;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    POP,
    CAPT,
    WRITE,
    DONE
  } opsum_wb_state_t;

  // Clamp each signed psum half of a packed word to zero when negative.
  function automatic logic [2*PSUM_W-1:0] relu_pair(input logic [2*PSUM_W-1:0] word);
    logic [2*PSUM_W-1:0] res;
    res[2*PSUM_W-1:PSUM_W] = word[2*PSUM_W-1] ? '0 : word[2*PSUM_W-1:PSUM_W];
    res[PSUM_W-1:0]        = word[PSUM_W-1]   ? '0 : word[PSUM_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/opsum_writeback_if.sv
// rtl/opsum_writeback_if.sv - GLB write request bus with ready backpressure
interface opsum_writeback_if;
  import conv_pkg::*;

  logic              glb_we_o;
  logic [GLB_AW-1:0] glb_addr_o;
  logic [31:0]       glb_wdata_o;
  logic              glb_ready_i;

  modport master (output glb_we_o, output glb_addr_o, output glb_wdata_o, input glb_ready_i);
  modport slave  (input glb_we_o, input glb_addr_o, input glb_wdata_o, output glb_ready_i);

endinterface

// File: rtl/opsum_wb_addr_gen.sv
// rtl/opsum_wb_addr_gen.sv - word-major channel/word counters and GLB address accumulators
module opsum_wb_addr_gen
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [GLB_AW-1:0] base_i,
  input  logic [GLB_AW-1:0] stride_i,
  input  logic [5:0]        ch_num_i,
  input  logic [15:0]       words_i,
  output logic [4:0]        ch_o,
  output logic [GLB_AW-1:0] addr_o,
  output logic              last_o
);

  logic [GLB_AW-1:0] base_r;
  logic [GLB_AW-1:0] stride_r;
  logic [5:0]        ch_num_r;
  logic [15:0]       words_r;
  logic [GLB_AW-1:0] ch_base;
  logic [GLB_AW-1:0] word_off;
  logic [4:0]        ch_r;
  logic [15:0]       w_r;
  logic              last_ch;
  logic              last_word;

  assign last_ch   = ({1'b0, ch_r} == (ch_num_r - 6'd1));
  assign last_word = (w_r == (words_r - 16'd1));
  assign last_o    = last_ch && last_word;
  assign ch_o      = ch_r;
  // Address wraps modulo 2^32 by construction of the adder width.
  assign addr_o    = ch_base + word_off;

  // Latch job configuration on load; on each accepted write step the channel,
  // rewinding to channel 0 and bumping the word offset when the channel wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      stride_r <= '0;
      ch_num_r <= '0;
      words_r  <= '0;
      ch_base  <= '0;
      word_off <= '0;
      ch_r     <= '0;
      w_r      <= '0;
    end else if (load) begin
      base_r   <= base_i;
      stride_r <= stride_i;
      ch_num_r <= ch_num_i;
      words_r  <= words_i;
      ch_base  <= base_i;
      word_off <= '0;
      ch_r     <= '0;
      w_r      <= '0;
    end else if (step) begin
      if (last_ch) begin
        ch_r     <= '0;
        ch_base  <= base_r;
        word_off <= word_off + 32'd4;
        w_r      <= w_r + 16'd1;
      end else begin
        ch_r    <= ch_r + 5'd1;
        ch_base <= ch_base + stride_r;
      end
    end
  end

endmodule

// File: rtl/opsum_writeback.sv
// rtl/opsum_writeback.sv - drains opsum FIFOs word-major into GLB; optional psum clamp via OPSUM_WB_RELU_EN
module opsum_writeback
  import conv_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [5:0]                    ch_num_i,
  input  logic [15:0]                   words_per_ch_i,
  input  logic [GLB_AW-1:0]             glb_base_addr_i,
  input  logic [GLB_AW-1:0]             ch_stride_i,
  input  logic [NUM_CH-1:0]             opsum_fifo_empty,
  input  logic [NUM_CH-1:0][31:0]       opsum_pop_data,
  output logic [NUM_CH-1:0]             opsum_pop_en,
  output logic [NUM_CH-1:0]             opsum_pop_mod,
  opsum_writeback_if.master             glb,
  output logic                          busy_o,
  output logic                          done_o
);

  opsum_wb_state_t   state;
  logic [4:0]        ch;
  logic [GLB_AW-1:0] gen_addr;
  logic              last_xfer;
  logic              load;
  logic              step;
  logic [NUM_CH-1:0] ch_sel;
  logic [31:0]       capt_word;

  assign load = (state == IDLE) && start_i;
  assign step = (state == WRITE) && glb.glb_ready_i;

  opsum_wb_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .base_i   (glb_base_addr_i),
    .stride_i (ch_stride_i),
    .ch_num_i (ch_num_i),
    .words_i  (words_per_ch_i),
    .ch_o     (ch),
    .addr_o   (gen_addr),
    .last_o   (last_xfer)
  );

  // One-hot channel select and the word that will be written for this channel.
  always_comb begin
    ch_sel = '0;
    ch_sel[ch] = 1'b1;
`ifdef OPSUM_WB_RELU_EN
    capt_word = relu_pair(opsum_pop_data[ch]);
`else
    capt_word = opsum_pop_data[ch];
`endif
  end

  // Drain FSM; every output is registered and changes together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      opsum_pop_en    <= '0;
      opsum_pop_mod   <= '0;
      glb.glb_we_o    <= 1'b0;
      glb.glb_addr_o  <= '0;
      glb.glb_wdata_o <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (ch_num_i == 6'd0 || words_per_ch_i == 16'd0) state <= DONE;
            else                                              state <= SCAN;
          end
        end
        SCAN: begin
          if (!opsum_fifo_empty[ch]) begin
            opsum_pop_en  <= ch_sel;
            opsum_pop_mod <= ch_sel;
            state         <= POP;
          end
        end
        POP: begin
          opsum_pop_en  <= '0;
          opsum_pop_mod <= '0;
          state         <= CAPT;
        end
        CAPT: begin
          glb.glb_we_o    <= 1'b1;
          glb.glb_addr_o  <= gen_addr;
          glb.glb_wdata_o <= capt_word;
          state           <= WRITE;
        end
        WRITE: begin
          if (glb.glb_ready_i) begin
            glb.glb_we_o <= 1'b0;
            state        <= last_xfer ? DONE : SCAN;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opsum_writeback.sv
// tb/tb_opsum_writeback.sv - directed bench for opsum_writeback with a FIFO bank model and GLB write monitor
module tb_opsum_writeback;
  import conv_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start_i = 1'b0;
  logic [5:0]              ch_num_i = '0;
  logic [15:0]             words_per_ch_i = '0;
  logic [31:0]             glb_base_addr_i = '0;
  logic [31:0]             ch_stride_i = '0;
  logic [NUM_CH-1:0]       opsum_fifo_empty;
  logic [NUM_CH-1:0][31:0] opsum_pop_data = '0;
  logic [NUM_CH-1:0]       opsum_pop_en;
  logic [NUM_CH-1:0]       opsum_pop_mod;
  logic                    busy_o;
  logic                    done_o;

  opsum_writeback_if glb_if ();

  opsum_writeback dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .ch_num_i         (ch_num_i),
    .words_per_ch_i   (words_per_ch_i),
    .glb_base_addr_i  (glb_base_addr_i),
    .ch_stride_i      (ch_stride_i),
    .opsum_fifo_empty (opsum_fifo_empty),
    .opsum_pop_data   (opsum_pop_data),
    .opsum_pop_en     (opsum_pop_en),
    .opsum_pop_mod    (opsum_pop_mod),
    .glb              (glb_if),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  logic [31:0] fmem [NUM_CH][16];
  int          wp [NUM_CH];
  int          rp [NUM_CH];
  int          pops = 0;
  int          multi_err = 0;
  int          mod_err = 0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  int          wr_n = 0;
  int          done_n = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      wp[c] = 0;
      rp[c] = 0;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) opsum_fifo_empty[c] = (wp[c] == rp[c]);
  end

  // FIFO bank model: popped word appears on pop_data in the cycle after the strobe.
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (opsum_pop_en[c]) begin
        opsum_pop_data[c] <= fmem[c][rp[c] % 16];
        rp[c] <= rp[c] + 1;
      end
    end
    if (opsum_pop_en != '0) pops <= pops + 1;
    if ($countones(opsum_pop_en) > 1) multi_err <= multi_err + 1;
    if (opsum_pop_en != opsum_pop_mod) mod_err <= mod_err + 1;
    if (glb_if.glb_we_o && glb_if.glb_ready_i) begin
      wa[wr_n % 64] <= glb_if.glb_addr_o;
      wd[wr_n % 64] <= glb_if.glb_wdata_o;
      wr_n <= wr_n + 1;
    end
    if (done_o) done_n <= done_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [31:0] d);
    fmem[c][wp[c] % 16] = d;
    wp[c] = wp[c] + 1;
  endtask

  task automatic start_job(input logic [5:0] c, input logic [15:0] w,
                           input logic [31:0] base, input logic [31:0] stride);
    start_i = 1'b1;
    ch_num_i = c;
    words_per_ch_i = w;
    glb_base_addr_i = base;
    ch_stride_i = stride;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!done_o && n < maxc) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  int n;
  int p0, w0, d0;
  logic [31:0] exp_a, exp_b;

  initial begin
    glb_if.glb_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_we", {31'd0, glb_if.glb_we_o}, 32'd0);
    chk("rst_addr", glb_if.glb_addr_o, 32'd0);
    chk("rst_wdata", glb_if.glb_wdata_o, 32'd0);
    chk("rst_pop_en", opsum_pop_en, 32'd0);
    chk("rst_pop_mod", opsum_pop_mod, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: C=2 W=2, word-major order, best-case throughput
    push(0, 32'h1111_0000); push(0, 32'h2222_0002);
    push(1, 32'h3333_0001); push(1, 32'h4444_0003);
    glb_if.glb_ready_i = 1'b1;
    p0 = pops; w0 = wr_n; d0 = done_n;
    start_job(6'd2, 16'd2, 32'h0000_1000, 32'h0000_0100);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    wait_done(100, n);
    chk("t1_latency", n, 32'd17);
    chk("t1_busy_end", {31'd0, busy_o}, 32'd0);
    chk("t1_writes", wr_n - w0, 32'd4);
    chk("t1_pops", pops - p0, 32'd4);
    chk("t1_a0", wa[w0], 32'h0000_1000);
    chk("t1_a1", wa[w0+1], 32'h0000_1100);
    chk("t1_a2", wa[w0+2], 32'h0000_1004);
    chk("t1_a3", wa[w0+3], 32'h0000_1104);
    chk("t1_d0", wd[w0], 32'h1111_0000);
    chk("t1_d1", wd[w0+1], 32'h3333_0001);
    chk("t1_d2", wd[w0+2], 32'h2222_0002);
    chk("t1_d3", wd[w0+3], 32'h4444_0003);
    tick();
    chk("t1_done_once", done_n - d0, 32'd1);

    // Test 2: channel 1 empty holds SCAN; address wraps modulo 2^32
    push(0, 32'h0101_0202);
    p0 = pops; w0 = wr_n;
    start_job(6'd2, 16'd1, 32'hFFFF_FFF0, 32'h0000_0020);
    for (int i = 0; i < 14; i++) tick();
    chk("t2_stall_pops", pops - p0, 32'd1);
    chk("t2_stall_writes", wr_n - w0, 32'd1);
    chk("t2_stall_busy", {31'd0, busy_o}, 32'd1);
    chk("t2_stall_pop_en", opsum_pop_en, 32'd0);
    push(1, 32'h0303_0404);
    wait_done(50, n);
    chk("t2_writes", wr_n - w0, 32'd2);
    chk("t2_a0", wa[w0], 32'hFFFF_FFF0);
    chk("t2_a1", wa[w0+1], 32'h0000_0010);
    chk("t2_d1", wd[w0+1], 32'h0303_0404);
    tick();

    // Test 3: ready low for 5 cycles in WRITE keeps the request stable
    push(0, 32'h5555_0005); push(0, 32'h6666_0006);
    glb_if.glb_ready_i = 1'b0;
    p0 = pops; w0 = wr_n;
    start_job(6'd1, 16'd2, 32'h0000_3000, 32'h0000_0000);
    n = 0;
    while (!glb_if.glb_we_o && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t3_we_hold", {31'd0, glb_if.glb_we_o}, 32'd1);
      chk("t3_addr_hold", glb_if.glb_addr_o, 32'h0000_3000);
      chk("t3_data_hold", glb_if.glb_wdata_o, 32'h5555_0005);
      tick();
    end
    chk("t3_stall_pops", pops - p0, 32'd1);
    glb_if.glb_ready_i = 1'b1;
    wait_done(50, n);
    chk("t3_pops", pops - p0, 32'd2);
    chk("t3_writes", wr_n - w0, 32'd2);
    chk("t3_a1", wa[w0+1], 32'h0000_3004);
    chk("t3_d1", wd[w0+1], 32'h6666_0006);
    tick();

    // Test 4: negative psum halves, clamped only in the clamp build
    push(0, 32'hFFF0_0012); push(0, 32'h8000_7FFF);
    w0 = wr_n;
    start_job(6'd1, 16'd2, 32'h0000_4000, 32'h0000_0000);
    wait_done(50, n);
`ifdef OPSUM_WB_RELU_EN
    exp_a = 32'h0000_0012;
    exp_b = 32'h0000_7FFF;
`else
    exp_a = 32'hFFF0_0012;
    exp_b = 32'h8000_7FFF;
`endif
    chk("t4_d0", wd[w0], exp_a);
    chk("t4_d1", wd[w0+1], exp_b);
    tick();

    // Test 5: reset during second WRITE aborts, restart begins at c=0 w=0
    push(0, 32'h0A0A_0001); push(0, 32'h0A0A_0002);
    push(1, 32'h0B0B_0001); push(1, 32'h0B0B_0002);
    w0 = wr_n; d0 = done_n;
    start_job(6'd2, 16'd2, 32'h0000_6000, 32'h0000_0100);
    n = 0;
    while (!(glb_if.glb_we_o && wr_n == w0 + 1) && n < 50) begin
      tick();
      n++;
    end
    chk("t5_in_write2", {31'd0, glb_if.glb_we_o}, 32'd1);
    rst = 1'b1;
    glb_if.glb_ready_i = 1'b0;
    tick();
    rst = 1'b0;
    glb_if.glb_ready_i = 1'b1;
    chk("t5_we", {31'd0, glb_if.glb_we_o}, 32'd0);
    chk("t5_addr", glb_if.glb_addr_o, 32'd0);
    chk("t5_wdata", glb_if.glb_wdata_o, 32'd0);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_done", {31'd0, done_o}, 32'd0);
    chk("t5_pop_en", opsum_pop_en, 32'd0);
    tick();
    chk("t5_no_done", done_n - d0, 32'd0);
    chk("t5_writes_abort", wr_n - w0, 32'd1);
    w0 = wr_n;
    start_job(6'd2, 16'd1, 32'h0000_5000, 32'h0000_0010);
    wait_done(50, n);
    chk("t5_re_writes", wr_n - w0, 32'd2);
    chk("t5_re_a0", wa[w0], 32'h0000_5000);
    chk("t5_re_a1", wa[w0+1], 32'h0000_5010);
    chk("t5_re_d0", wd[w0], 32'h0A0A_0002);
    chk("t5_re_d1", wd[w0+1], 32'h0B0B_0002);
    tick();

    // Test 6: empty job completes via DONE; start while busy is ignored
    p0 = pops; w0 = wr_n;
    start_job(6'd0, 16'd5, 32'h0000_7000, 32'h0000_0004);
    chk("t6_busy", {31'd0, busy_o}, 32'd1);
    chk("t6_done_early", {31'd0, done_o}, 32'd0);
    start_i = 1'b1;
    ch_num_i = 6'd2;
    words_per_ch_i = 16'd1;
    tick();
    start_i = 1'b0;
    chk("t6_done", {31'd0, done_o}, 32'd1);
    chk("t6_busy_end", {31'd0, busy_o}, 32'd0);
    tick();
    chk("t6_done_pulse", {31'd0, done_o}, 32'd0);
    chk("t6_ignored_start", {31'd0, busy_o}, 32'd0);
    chk("t6_pops", pops - p0, 32'd0);
    chk("t6_writes", wr_n - w0, 32'd0);

    // words_per_ch = 0 also finishes without traffic
    start_job(6'd3, 16'd0, 32'h0000_8000, 32'h0000_0004);
    tick();
    chk("t6w_done", {31'd0, done_o}, 32'd1);
    chk("t6w_writes", wr_n - w0, 32'd0);

    tick();
    chk("pop_onehot", multi_err, 32'd0);
    chk("pop_mod_match", mod_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
